// File: rtl/bus_initiator.sv
// bus_initiator: single-master 68000-style bus initiator. Runs one read or
// write bus cycle per accepted command and reports completion through a
// one-cycle response strobe. All state changes on the falling clock edge.
// Optional feature macro: BUS_INITIATOR_TIMEOUT_EN (forced STROBE timeout
// after TIMEOUT_CYCLES edges); undefined means STROBE waits indefinitely.
module bus_initiator #(
  parameter  int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned AW = 24,
  localparam int unsigned DW = 16,
  localparam int unsigned TW = 16
) (
  input  logic          MCLK_IN,
  input  logic          RUN_IN,
  input  logic          CMD_VALID_IN,
  output logic          CMD_READY,
  input  logic          CMD_WRITE_IN,
  input  logic          CMD_UDS_IN,
  input  logic          CMD_LDS_IN,
  input  logic [AW-1:0] CMD_ADDR_IN,
  input  logic [DW-1:0] CMD_WDATA_IN,
  output logic          RSP_VALID,
  output logic [DW-1:0] RSP_RDATA,
  output logic          RSP_ERROR,
  output logic          RSP_TIMEOUT,
  output logic          AS,
  output logic          WR,
  output logic          UDS,
  output logic          LDS,
  output logic [AW-1:0] ADDR,
  inout  wire  [DW-1:0] DATA,
  input  logic          DTACK_IN,
  input  logic          DTERROR_IN
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_STROBE, S_TERM} state_t;

  state_t        state_q;
  logic          as_q, wr_q, uds_q, lds_q;
  logic          ue_q, le_q;
  logic          ready_q, rsp_valid_q, error_q, timeout_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic          term_to_c;
  logic [DW-1:0] rd_lanes_c;

  // Reject out-of-range timeout settings at elaboration
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_initiator: TIMEOUT_CYCLES must be 1..65535");
  end

`ifdef BUS_INITIATOR_TIMEOUT_EN
  logic [TW-1:0] cnt_q;

  // Count STROBE edges; held at zero outside STROBE so it is clear on entry
  always_ff @(negedge MCLK_IN) begin
    if (!RUN_IN || state_q != S_STROBE) cnt_q <= '0;
    else                                cnt_q <= cnt_q + TW'(1);
  end

  assign term_to_c = (cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign term_to_c = 1'b0;
`endif

  // Read data with disabled byte lanes forced to zero
  assign rd_lanes_c = {ue_q ? DATA[15:8] : 8'h00, le_q ? DATA[7:0] : 8'h00};

  // Bus cycle sequencer with registered bus strobes and response
  always_ff @(negedge MCLK_IN) begin
    if (!RUN_IN) begin
      state_q     <= S_IDLE;
      as_q        <= 1'b0;
      wr_q        <= 1'b0;
      uds_q       <= 1'b0;
      lds_q       <= 1'b0;
      ue_q        <= 1'b0;
      le_q        <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (CMD_VALID_IN && ready_q) begin
            ue_q    <= CMD_UDS_IN;
            le_q    <= CMD_LDS_IN;
            wdata_q <= CMD_WDATA_IN;
            if (!CMD_UDS_IN && !CMD_LDS_IN) begin
              // Nothing to transfer: report an error without touching the bus
              state_q     <= S_TERM;
              rsp_valid_q <= 1'b1;
              error_q     <= 1'b1;
              timeout_q   <= 1'b0;
              rdata_q     <= '0;
            end else begin
              state_q <= S_ADDR;
              addr_q  <= CMD_ADDR_IN;
              as_q    <= 1'b1;
              wr_q    <= CMD_WRITE_IN;
            end
          end else begin
            ready_q <= !DTACK_IN && !DTERROR_IN;
          end
        end
        S_ADDR: begin
          state_q <= S_STROBE;
          uds_q   <= ue_q;
          lds_q   <= le_q;
        end
        S_STROBE: begin
          if (DTERROR_IN || DTACK_IN || term_to_c) begin
            state_q     <= S_TERM;
            as_q        <= 1'b0;
            wr_q        <= 1'b0;
            uds_q       <= 1'b0;
            lds_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            error_q     <= DTERROR_IN || !DTACK_IN;
            timeout_q   <= !DTERROR_IN && !DTACK_IN;
            rdata_q     <= (DTACK_IN && !DTERROR_IN && !wr_q) ? rd_lanes_c : '0;
          end
        end
        S_TERM: begin
          state_q <= S_IDLE;
          ready_q <= !DTACK_IN && !DTERROR_IN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign CMD_READY   = ready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rdata_q;
  assign RSP_ERROR   = error_q;
  assign RSP_TIMEOUT = timeout_q;
  assign AS          = as_q;
  assign WR          = wr_q;
  assign UDS         = uds_q;
  assign LDS         = lds_q;
  assign ADDR        = addr_q;
  assign DATA        = wr_q ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator. Inputs are driven and outputs sampled on
// the rising clock edge, half a cycle away from the falling active edge.
// The data bus carries pull-ups, so a released bus reads 16'hFFFF.
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        run, cmd_valid, cmd_write, cmd_uds, cmd_lds;
  logic [23:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_ready, rsp_valid, rsp_error, rsp_timeout;
  logic [15:0] rsp_rdata;
  logic        as_o, wr_o, uds_o, lds_o;
  logic [23:0] addr_o;
  logic        dtack, dterror;
  logic        rsp_drive;
  logic [15:0] rsp_data;
  wire  [15:0] data_bus;

  int checks = 0;
  int failures = 0;

  assign data_bus = rsp_drive ? rsp_data : 16'hzzzz;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (data_bus[g]);
  end

  always #5 clk = ~clk;

  bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .MCLK_IN(clk), .RUN_IN(run),
    .CMD_VALID_IN(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE_IN(cmd_write),
    .CMD_UDS_IN(cmd_uds), .CMD_LDS_IN(cmd_lds), .CMD_ADDR_IN(cmd_addr),
    .CMD_WDATA_IN(cmd_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERROR(rsp_error),
    .RSP_TIMEOUT(rsp_timeout),
    .AS(as_o), .WR(wr_o), .UDS(uds_o), .LDS(lds_o), .ADDR(addr_o),
    .DATA(data_bus), .DTACK_IN(dtack), .DTERROR_IN(dterror)
  );

  // One falling (active) edge passes between consecutive rising edges
  task automatic step();
    @(posedge clk);
  endtask

  // Wait for ready (bounded), present one command, return just after the accept edge
  task automatic issue(input logic w, input logic u, input logic l,
                       input logic [23:0] a, input logic [15:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL issue_ready got=%0b exp=1", cmd_ready); end
    cmd_write = w; cmd_uds = u; cmd_lds = l; cmd_addr = a; cmd_wdata = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    run = 1'b0; step(); step();
    checks++; if ({as_o, wr_o, uds_o, lds_o} !== 4'b0000) begin failures++; $display("FAIL rst_strobes got=%b exp=0000", {as_o, wr_o, uds_o, lds_o}); end
    checks++; if (addr_o !== 24'h0) begin failures++; $display("FAIL rst_addr got=%0h exp=0", addr_o); end
    checks++; if ({rsp_valid, rsp_error, rsp_timeout, cmd_ready} !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {rsp_valid, rsp_error, rsp_timeout, cmd_ready}); end
    checks++; if (rsp_rdata !== 16'h0) begin failures++; $display("FAIL rst_rdata got=%0h exp=0", rsp_rdata); end
    checks++; if (data_bus !== 16'hFFFF) begin failures++; $display("FAIL rst_data got=%0h exp=ffff", data_bus); end
    run = 1'b1; step();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rise got=%0b exp=1", cmd_ready); end
  endtask

  task automatic test_write();
    issue(1'b1, 1'b1, 1'b1, 24'h000000, 16'hA55A);
    checks++; if ({as_o, wr_o, uds_o, lds_o} !== 4'b1100) begin failures++; $display("FAIL wr_addr_strobes got=%b exp=1100", {as_o, wr_o, uds_o, lds_o}); end
    checks++; if (data_bus !== 16'hA55A) begin failures++; $display("FAIL wr_addr_data got=%0h exp=a55a", data_bus); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL wr_addr_ready got=%0b exp=0", cmd_ready); end
    step();
    checks++; if ({as_o, wr_o, uds_o, lds_o} !== 4'b1111) begin failures++; $display("FAIL wr_strobe_strobes got=%b exp=1111", {as_o, wr_o, uds_o, lds_o}); end
    checks++; if (data_bus !== 16'hA55A) begin failures++; $display("FAIL wr_strobe_data got=%0h exp=a55a", data_bus); end
    dtack = 1'b1; step();
    checks++; if ({as_o, wr_o, uds_o, lds_o} !== 4'b0000) begin failures++; $display("FAIL wr_term_strobes got=%b exp=0000", {as_o, wr_o, uds_o, lds_o}); end
    checks++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b100) begin failures++; $display("FAIL wr_term_rsp got=%b exp=100", {rsp_valid, rsp_error, rsp_timeout}); end
    checks++; if (rsp_rdata !== 16'h0) begin failures++; $display("FAIL wr_term_rdata got=%0h exp=0", rsp_rdata); end
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL wr_term_ready got=%0b exp=0", cmd_ready); end
    dtack = 1'b0; step();
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL wr_idle_valid_ready got=%b exp=01", {rsp_valid, cmd_ready}); end
    checks++; if (data_bus !== 16'hFFFF) begin failures++; $display("FAIL wr_idle_data got=%0h exp=ffff", data_bus); end
  endtask

  task automatic test_read();
    issue(1'b0, 1'b0, 1'b1, 24'h100001, 16'hBEEF);
    checks++; if ({as_o, wr_o, uds_o, lds_o} !== 4'b1000) begin failures++; $display("FAIL rd_addr_strobes got=%b exp=1000", {as_o, wr_o, uds_o, lds_o}); end
    checks++; if (addr_o !== 24'h100001) begin failures++; $display("FAIL rd_addr got=%0h exp=100001", addr_o); end
    checks++; if (data_bus !== 16'hFFFF) begin failures++; $display("FAIL rd_addr_data got=%0h exp=ffff", data_bus); end
    step();
    checks++; if ({as_o, wr_o, uds_o, lds_o} !== 4'b1001) begin failures++; $display("FAIL rd_strobe_strobes got=%b exp=1001", {as_o, wr_o, uds_o, lds_o}); end
    rsp_data = 16'h5AC3; rsp_drive = 1'b1;
    step();
    checks++; if ({rsp_valid, as_o, lds_o} !== 3'b011) begin failures++; $display("FAIL rd_wait1 got=%b exp=011", {rsp_valid, as_o, lds_o}); end
    checks++; if (data_bus !== 16'h5AC3) begin failures++; $display("FAIL rd_bus_undriven got=%0h exp=5ac3", data_bus); end
    step();
    checks++; if ({rsp_valid, as_o, lds_o} !== 3'b011) begin failures++; $display("FAIL rd_wait2 got=%b exp=011", {rsp_valid, as_o, lds_o}); end
    checks++; if (addr_o !== 24'h100001) begin failures++; $display("FAIL rd_addr_stable got=%0h exp=100001", addr_o); end
    dtack = 1'b1; step();
    checks++; if ({rsp_valid, rsp_error, as_o} !== 3'b100) begin failures++; $display("FAIL rd_term got=%b exp=100", {rsp_valid, rsp_error, as_o}); end
    checks++; if (rsp_rdata !== 16'h00C3) begin failures++; $display("FAIL rd_rdata got=%0h exp=00c3", rsp_rdata); end
    dtack = 1'b0; rsp_drive = 1'b0; step();
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL rd_idle got=%b exp=01", {rsp_valid, cmd_ready}); end
    checks++; if (rsp_rdata !== 16'h00C3) begin failures++; $display("FAIL rd_rdata_hold got=%0h exp=00c3", rsp_rdata); end
  endtask

  task automatic test_timeout();
    issue(1'b0, 1'b1, 1'b1, 24'h300000, 16'h0000);
    step();
`ifdef BUS_INITIATOR_TIMEOUT_EN
    step(); step(); step();
    checks++; if ({rsp_valid, as_o, uds_o} !== 3'b011) begin failures++; $display("FAIL to_wait got=%b exp=011", {rsp_valid, as_o, uds_o}); end
    step();
    checks++; if ({rsp_valid, rsp_error, rsp_timeout, as_o} !== 4'b1110) begin failures++; $display("FAIL to_term got=%b exp=1110", {rsp_valid, rsp_error, rsp_timeout, as_o}); end
    checks++; if (rsp_rdata !== 16'h0) begin failures++; $display("FAIL to_rdata got=%0h exp=0", rsp_rdata); end
    step();
`else
    begin
      int seen = 0;
      for (int i = 0; i < 1000; i++) begin step(); if (rsp_valid === 1'b1) seen++; end
      checks++; if (seen != 0) begin failures++; $display("FAIL noto_rsp got=%0d exp=0", seen); end
    end
    checks++; if ({as_o, uds_o, lds_o} !== 3'b111) begin failures++; $display("FAIL noto_strobe got=%b exp=111", {as_o, uds_o, lds_o}); end
    dtack = 1'b1; rsp_data = 16'h0F0F; rsp_drive = 1'b1; step();
    checks++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b100) begin failures++; $display("FAIL noto_term got=%b exp=100", {rsp_valid, rsp_error, rsp_timeout}); end
    checks++; if (rsp_rdata !== 16'h0F0F) begin failures++; $display("FAIL noto_rdata got=%0h exp=0f0f", rsp_rdata); end
    dtack = 1'b0; rsp_drive = 1'b0; step();
`endif
  endtask

  task automatic test_error();
    issue(1'b0, 1'b1, 1'b1, 24'h200000, 16'h0000);
    step();
    dterror = 1'b1; dtack = 1'b1; rsp_data = 16'h1234; rsp_drive = 1'b1;
    step();
    checks++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b110) begin failures++; $display("FAIL err_rsp got=%b exp=110", {rsp_valid, rsp_error, rsp_timeout}); end
    checks++; if (rsp_rdata !== 16'h0) begin failures++; $display("FAIL err_rdata got=%0h exp=0", rsp_rdata); end
    checks++; if ({as_o, uds_o, lds_o} !== 3'b000) begin failures++; $display("FAIL err_strobes got=%b exp=000", {as_o, uds_o, lds_o}); end
    dterror = 1'b0; dtack = 1'b0; rsp_drive = 1'b0; step();
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin failures++; $display("FAIL err_idle got=%b exp=01", {rsp_valid, cmd_ready}); end
  endtask

  task automatic test_empty();
    issue(1'b1, 1'b0, 1'b0, 24'h500000, 16'hFACE);
    checks++; if ({rsp_valid, rsp_error, rsp_timeout} !== 3'b110) begin failures++; $display("FAIL empty_rsp got=%b exp=110", {rsp_valid, rsp_error, rsp_timeout}); end
    checks++; if ({as_o, wr_o, uds_o, lds_o} !== 4'b0000) begin failures++; $display("FAIL empty_bus got=%b exp=0000", {as_o, wr_o, uds_o, lds_o}); end
    checks++; if (data_bus !== 16'hFFFF) begin failures++; $display("FAIL empty_data got=%0h exp=ffff", data_bus); end
    step();
    checks++; if ({rsp_valid, as_o, cmd_ready} !== 3'b001) begin failures++; $display("FAIL empty_idle got=%b exp=001", {rsp_valid, as_o, cmd_ready}); end
  endtask

  task automatic test_run_abort();
    issue(1'b1, 1'b1, 1'b0, 24'h400002, 16'h1111);
    step();
    checks++; if ({as_o, wr_o, uds_o, lds_o} !== 4'b1110) begin failures++; $display("FAIL abort_strobe got=%b exp=1110", {as_o, wr_o, uds_o, lds_o}); end
    checks++; if (data_bus !== 16'h1111) begin failures++; $display("FAIL abort_wdata got=%0h exp=1111", data_bus); end
    run = 1'b0; dtack = 1'b1; step();
    checks++; if ({as_o, wr_o, uds_o, lds_o} !== 4'b0000) begin failures++; $display("FAIL abort_strobes got=%b exp=0000", {as_o, wr_o, uds_o, lds_o}); end
    checks++; if (data_bus !== 16'hFFFF) begin failures++; $display("FAIL abort_data got=%0h exp=ffff", data_bus); end
    checks++; if ({rsp_valid, cmd_ready} !== 2'b00) begin failures++; $display("FAIL abort_rsp got=%b exp=00", {rsp_valid, cmd_ready}); end
    checks++; if (addr_o !== 24'h0) begin failures++; $display("FAIL abort_addr got=%0h exp=0", addr_o); end
    run = 1'b1; step(); step();
    checks++; if ({rsp_valid, cmd_ready} !== 2'b00) begin failures++; $display("FAIL abort_dtack_hold got=%b exp=00", {rsp_valid, cmd_ready}); end
    dtack = 1'b0; step();
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_release got=%0b exp=1", cmd_ready); end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b1, 1'b1, 24'h000010, 16'h1234);
    // Second command presented immediately and held while the first runs
    cmd_write = 1'b0; cmd_uds = 1'b1; cmd_lds = 1'b1; cmd_addr = 24'h000020; cmd_valid = 1'b1;
    step();
    checks++; if ({as_o, cmd_ready, addr_o} !== {2'b10, 24'h000010}) begin failures++; $display("FAIL b2b_first_hold got=%0h exp=%0h", {as_o, cmd_ready, addr_o}, {2'b10, 24'h000010}); end
    dtack = 1'b1; step();
    dtack = 1'b0;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b10) begin failures++; $display("FAIL b2b_term got=%b exp=10", {rsp_valid, cmd_ready}); end
    step();
    checks++; if ({as_o, cmd_ready} !== 2'b01) begin failures++; $display("FAIL b2b_idle got=%b exp=01", {as_o, cmd_ready}); end
    step();
    cmd_valid = 1'b0;
    checks++; if ({as_o, wr_o, addr_o} !== {2'b10, 24'h000020}) begin failures++; $display("FAIL b2b_second got=%0h exp=%0h", {as_o, wr_o, addr_o}, {2'b10, 24'h000020}); end
    step();
    rsp_data = 16'h7777; rsp_drive = 1'b1; dtack = 1'b1; step();
    checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 16'h7777}) begin failures++; $display("FAIL b2b_rdata got=%0h exp=%0h", {rsp_valid, rsp_rdata}, {1'b1, 16'h7777}); end
    dtack = 1'b0; rsp_drive = 1'b0; step();
  endtask

  initial begin
    run = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_uds = 1'b0; cmd_lds = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; dtack = 1'b0; dterror = 1'b0;
    rsp_drive = 1'b0; rsp_data = '0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_error();
    test_empty();
    test_run_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
